// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card insert -> PIN -> auth -> menu -> op -> eject, with PIN lockout and idle timeout.
// Build option ATM_LOCKOUT_MEM_EN remembers the last locked account so re-inserting it goes straight to LOCKED.
module atm_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic [ACC_W-1:0] acc_number,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [2:0]       menu_option,
  input  logic             menu_valid,
  output logic             lookup_req,
  output logic [ACC_W-1:0] lookup_acc,
  output logic [PIN_W-1:0] lookup_pin,
  input  logic             lookup_ack,
  input  logic             lookup_pass,
  output logic             op_req,
  output logic [2:0]       op_code,
  input  logic             op_ack,
  output logic             session_active,
  output logic             locked,
  output logic             timeout_evt,
  output logic             card_eject,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_PIN = 3'd1,
    S_AUTH    = 3'd2,
    S_MENU    = 3'd3,
    S_EXEC    = 3'd4,
    S_EJECT   = 3'd5,
    S_LOCKED  = 3'd6
  } state_e;

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       TRIES_MAX = 3'(MAX_PIN_TRIES);

  state_e           state_q;
  logic             card_in_q;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic [2:0]       tries_q;
  logic [2:0]       tries_d;
  logic             lookup_req_q;
  logic [ACC_W-1:0] lookup_acc_q;
  logic [PIN_W-1:0] lookup_pin_q;
  logic             op_req_q;
  logic [2:0]       op_code_q;
  logic             session_active_q;
  logic             locked_q;
  logic             timeout_evt_q;
  logic             card_eject_q;

  logic card_rise;
  logic tmr_exp;
  logic menu_is_op;
  logic lock_hit;

  assign card_rise  = card_in & ~card_in_q;
  assign tmr_exp    = (timer_q == TMR_LAST);
  assign menu_is_op = (menu_option >= 3'd3);
  assign timer_d    = timer_q + TMR_W'(1);
  assign tries_d    = tries_q + 3'd1;

`ifdef ATM_LOCKOUT_MEM_EN
  logic [ACC_W-1:0] lock_acc_q;
  logic             lock_vld_q;

  assign lock_hit = lock_vld_q && (acc_number == lock_acc_q);

  // Remembers the account that exhausted its PIN tries; only reset forgets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_acc_q <= '0;
      lock_vld_q <= 1'b0;
    end else if (state_q == S_AUTH && lookup_ack && !lookup_pass && tries_d == TRIES_MAX) begin
      lock_acc_q <= lookup_acc_q;
      lock_vld_q <= 1'b1;
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      card_in_q        <= 1'b0;
      timer_q          <= '0;
      tries_q          <= '0;
      lookup_req_q     <= 1'b0;
      lookup_acc_q     <= '0;
      lookup_pin_q     <= '0;
      op_req_q         <= 1'b0;
      op_code_q        <= '0;
      session_active_q <= 1'b0;
      locked_q         <= 1'b0;
      timeout_evt_q    <= 1'b0;
      card_eject_q     <= 1'b0;
    end else begin
      card_in_q     <= card_in;
      timeout_evt_q <= 1'b0;
      card_eject_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          tries_q <= '0;
          if (card_rise) begin
            lookup_acc_q <= acc_number;
            timer_q      <= '0;
            if (lock_hit) begin
              state_q      <= S_LOCKED;
              locked_q     <= 1'b1;
              card_eject_q <= 1'b1;
            end else begin
              state_q <= S_GET_PIN;
            end
          end
        end

        // A pin strobe beats a simultaneous timer expiry; card removal beats both.
        S_GET_PIN: begin
          if (!card_in) begin
            state_q <= S_IDLE;
          end else if (pin_valid) begin
            lookup_pin_q <= pin;
            lookup_req_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= S_AUTH;
          end else if (tmr_exp) begin
            timeout_evt_q <= 1'b1;
            card_eject_q  <= 1'b1;
            state_q       <= S_EJECT;
          end else begin
            timer_q <= timer_d;
          end
        end

        S_AUTH: begin
          if (lookup_ack) begin
            lookup_req_q <= 1'b0;
            timer_q      <= '0;
            if (lookup_pass) begin
              tries_q <= '0;
              if (!card_in) begin
                state_q <= S_IDLE;
              end else begin
                state_q          <= S_MENU;
                session_active_q <= 1'b1;
              end
            end else begin
              tries_q <= tries_d;
              if (tries_d == TRIES_MAX) begin
                state_q      <= S_LOCKED;
                locked_q     <= 1'b1;
                card_eject_q <= 1'b1;
              end else if (!card_in) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_GET_PIN;
              end
            end
          end
        end

        // Options 1 and 2 are ignored apart from restarting the idle timer.
        S_MENU: begin
          if (!card_in) begin
            state_q          <= S_IDLE;
            session_active_q <= 1'b0;
          end else if (menu_valid) begin
            timer_q <= '0;
            if (menu_is_op) begin
              op_code_q <= menu_option;
              op_req_q  <= 1'b1;
              state_q   <= S_EXEC;
            end else if (menu_option == 3'd0) begin
              card_eject_q     <= 1'b1;
              session_active_q <= 1'b0;
              state_q          <= S_EJECT;
            end
          end else if (tmr_exp) begin
            timeout_evt_q    <= 1'b1;
            card_eject_q     <= 1'b1;
            session_active_q <= 1'b0;
            state_q          <= S_EJECT;
          end else begin
            timer_q <= timer_d;
          end
        end

        // The datapath handshake always completes, even if the card was pulled mid-operation.
        S_EXEC: begin
          if (op_ack) begin
            op_req_q <= 1'b0;
            timer_q  <= '0;
            if (!card_in) begin
              state_q          <= S_IDLE;
              session_active_q <= 1'b0;
            end else begin
              state_q <= S_MENU;
            end
          end
        end

        S_EJECT: begin
          if (!card_in) begin
            state_q <= S_IDLE;
          end
        end

        S_LOCKED: begin
          if (!card_in) begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
          end
        end

        default: begin
          state_q          <= S_IDLE;
          lookup_req_q     <= 1'b0;
          op_req_q         <= 1'b0;
          session_active_q <= 1'b0;
          locked_q         <= 1'b0;
        end
      endcase
    end
  end

  assign state          = state_q;
  assign lookup_req     = lookup_req_q;
  assign lookup_acc     = lookup_acc_q;
  assign lookup_pin     = lookup_pin_q;
  assign op_req         = op_req_q;
  assign op_code        = op_code_q;
  assign session_active = session_active_q;
  assign locked         = locked_q;
  assign timeout_evt    = timeout_evt_q;
  assign card_eject     = card_eject_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: hand-computed expectations, sampled on the falling clock edge.
module tb_atm_session_ctrl;

  logic        clk;
  logic        rst_n;
  logic        card_in;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        pin_valid;
  logic [2:0]  menu_option;
  logic        menu_valid;
  logic        lookup_req;
  logic [11:0] lookup_acc;
  logic [3:0]  lookup_pin;
  logic        lookup_ack;
  logic        lookup_pass;
  logic        op_req;
  logic [2:0]  op_code;
  logic        op_ack;
  logic        session_active;
  logic        locked;
  logic        timeout_evt;
  logic        card_eject;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  atm_session_ctrl #(
    .TIMEOUT_CYCLES(100),
    .MAX_PIN_TRIES (3),
    .ACC_W         (12),
    .PIN_W         (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .card_in       (card_in),
    .acc_number    (acc_number),
    .pin           (pin),
    .pin_valid     (pin_valid),
    .menu_option   (menu_option),
    .menu_valid    (menu_valid),
    .lookup_req    (lookup_req),
    .lookup_acc    (lookup_acc),
    .lookup_pin    (lookup_pin),
    .lookup_ack    (lookup_ack),
    .lookup_pass   (lookup_pass),
    .op_req        (op_req),
    .op_code       (op_code),
    .op_ack        (op_ack),
    .session_active(session_active),
    .locked        (locked),
    .timeout_evt   (timeout_evt),
    .card_eject    (card_eject),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic insert(input logic [11:0] acc);
    acc_number = acc;
    card_in    = 1'b1;
    tick();
  endtask

  task automatic remove();
    card_in = 1'b0;
    tick();
  endtask

  // PIN entry, one extra cycle with the request pending, then the datapath answer.
  task automatic do_auth(input logic [3:0] p, input logic pass_i);
    pin       = p;
    pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
    tick();
    check_val("auth_req_held", 32'(lookup_req), 32'd1);
    check_val("auth_pin_latched", 32'(lookup_pin), 32'(p));
    lookup_ack  = 1'b1;
    lookup_pass = pass_i;
    tick();
    lookup_ack  = 1'b0;
    lookup_pass = 1'b0;
    check_val("auth_req_drop", 32'(lookup_req), 32'd0);
  endtask

  task automatic menu(input logic [2:0] opt);
    menu_option = opt;
    menu_valid  = 1'b1;
    tick();
    menu_valid  = 1'b0;
  endtask

  // Counts cycles op_req is seen high; op_ack is raised in the cycle the count reaches ack_at.
  task automatic run_op(input int ack_at, output int n);
    n = 0;
    for (int i = 0; i < 20 && (n == 0 || op_req); i++) begin
      if (op_req) n++;
      op_ack = op_req && (n == ack_at);
      tick();
    end
    op_ack = 1'b0;
  endtask

  int  n;
  logic seen_to;

  initial begin
    rst_n = 1'b0; card_in = 1'b0; acc_number = '0; pin = '0; pin_valid = 1'b0;
    menu_option = '0; menu_valid = 1'b0; lookup_ack = 1'b0; lookup_pass = 1'b0; op_ack = 1'b0;
    repeat (3) tick();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_lookup_req", 32'(lookup_req), 32'd0);
    check_val("rst_op_req", 32'(op_req), 32'd0);
    check_val("rst_flags", {28'd0, session_active, locked, timeout_evt, card_eject}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_no_card", 32'(state), 32'd0);

    // Normal session: balance enquiry, ignored option, then exit.
    insert(12'd2816);
    check_val("s1_get_pin", 32'(state), 32'd1);
    check_val("s1_acc_latched", 32'(lookup_acc), 32'd2816);
    do_auth(4'd6, 1'b1);
    check_val("s1_menu", 32'(state), 32'd3);
    check_val("s1_active", 32'(session_active), 32'd1);
    menu(3'd3);
    check_val("s1_exec", 32'(state), 32'd4);
    check_val("s1_op_code", 32'(op_code), 32'd3);
    run_op(2, n);
    check_val("s1_op_req_cycles", 32'(n), 32'd2);
    check_val("s1_back_menu", 32'(state), 32'd3);
    menu(3'd2);
    check_val("s1_opt2_state", 32'(state), 32'd3);
    check_val("s1_opt2_no_op", 32'(op_req), 32'd0);
    menu(3'd0);
    check_val("s1_exit_eject_state", 32'(state), 32'd5);
    check_val("s1_exit_eject_pulse", 32'(card_eject), 32'd1);
    check_val("s1_exit_no_timeout", 32'(timeout_evt), 32'd0);
    tick();
    check_val("s1_eject_one_cycle", 32'(card_eject), 32'd0);
    remove();
    check_val("s1_idle", 32'(state), 32'd0);

    // Three failed PIN tries lock the card.
    insert(12'd3467);
    for (int i = 0; i < 3; i++) begin
      do_auth(4'(i), 1'b0);
      if (i < 2) check_val("s2_retry_get_pin", 32'(state), 32'd1);
    end
    check_val("s2_locked_state", 32'(state), 32'd6);
    check_val("s2_locked", 32'(locked), 32'd1);
    check_val("s2_lock_eject", 32'(card_eject), 32'd1);
    tick();
    check_val("s2_locked_hold", 32'(locked), 32'd1);
    check_val("s2_eject_one_cycle", 32'(card_eject), 32'd0);
    remove();
    check_val("s2_idle", 32'(state), 32'd0);
    check_val("s2_unlocked", 32'(locked), 32'd0);
    insert(12'd3467);
`ifdef ATM_LOCKOUT_MEM_EN
    check_val("s2_reinsert_locked", 32'(state), 32'd6);
    check_val("s2_reinsert_eject", 32'(card_eject), 32'd1);
`else
    check_val("s2_reinsert_get_pin", 32'(state), 32'd1);
`endif
    remove();
    check_val("s2_reinsert_idle", 32'(state), 32'd0);

    // MENU idle timeout: 100 cycles in MENU, then EJECT with both pulses.
    insert(12'd100);
    do_auth(4'd1, 1'b1);
    seen_to = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      seen_to |= timeout_evt;
    end
    check_val("s3_no_early_timeout", 32'(seen_to), 32'd0);
    check_val("s3_still_menu", 32'(state), 32'd3);
    tick();
    check_val("s3_timeout_evt", 32'(timeout_evt), 32'd1);
    check_val("s3_timeout_eject", 32'(card_eject), 32'd1);
    check_val("s3_timeout_state", 32'(state), 32'd5);
    check_val("s3_inactive", 32'(session_active), 32'd0);
    tick();
    check_val("s3_timeout_one_cycle", 32'(timeout_evt), 32'd0);
    remove();

    // A menu strobe after 98 idle cycles restarts the timer.
    insert(12'd101);
    do_auth(4'd2, 1'b1);
    seen_to = 1'b0;
    for (int i = 0; i < 98; i++) begin
      tick();
      seen_to |= timeout_evt;
    end
    menu(3'd1);
    for (int i = 0; i < 98; i++) begin
      seen_to |= timeout_evt;
      tick();
    end
    check_val("s4_no_timeout", 32'(seen_to), 32'd0);
    check_val("s4_still_menu", 32'(state), 32'd3);
    remove();
    check_val("s4_pull_idle", 32'(state), 32'd0);
    check_val("s4_pull_no_eject", 32'(card_eject), 32'd0);

    // Card pulled mid-operation: handshake completes, then IDLE.
    insert(12'd200);
    do_auth(4'd3, 1'b1);
    menu(3'd7);
    check_val("s5_exec", 32'(state), 32'd4);
    card_in = 1'b0;
    run_op(5, n);
    check_val("s5_op_req_cycles", 32'(n), 32'd5);
    check_val("s5_idle", 32'(state), 32'd0);
    check_val("s5_inactive", 32'(session_active), 32'd0);

    // Asynchronous reset mid-EXEC clears everything at once.
    tick();
    insert(12'd5);
    do_auth(4'd4, 1'b1);
    menu(3'd4);
    check_val("s6_exec_op_req", 32'(op_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("s6_rst_state", 32'(state), 32'd0);
    check_val("s6_rst_op_req", 32'(op_req), 32'd0);
    check_val("s6_rst_active", 32'(session_active), 32'd0);
    check_val("s6_rst_acc", 32'(lookup_acc), 32'd0);
    card_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    insert(12'd3467);
    check_val("s6_post_rst_get_pin", 32'(state), 32'd1);
    remove();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
